// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_sched_pkg
// Purpose : Shared constants, FSM state type and the cyclic priority search
//           used by the adder share scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

  localparam int FP32_WIDTH         = 32;
  localparam int DEFAULT_VECTOR_LEN = 33;
  // Widest requester vector the priority search handles.
  localparam int MAX_REQ            = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_t;

  // Returns the first set bit of req at or after ptr, wrapping at num_req.
  // Scanning from the far end downwards lets the closest match win last.
  // Callers only use the result when at least one request bit is set.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [3:0]         ptr,
    input int                 num_req
  );
    logic [3:0] pick;
    logic [3:0] idx4;
    int         idx;
    pick = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < num_req) begin
        idx  = (int'(ptr) + i) % num_req;
        idx4 = idx[3:0];
        if (req[idx4]) pick = idx4;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_sched_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : adder_sched_tag_fifo
// Purpose : In-order FIFO of requester IDs for frames in flight in the adder.
//           A push while full is accepted only when a pop happens in the same
//           cycle.  DEPTH must be a power of two, at least 2.
// Ports   : clk, rst_n  - clock, asynchronous active-low reset
//           push, din   - write a tag
//           pop, dout   - read/remove the head tag (dout is the head)
//           full, empty - occupancy flags
//           count       - number of stored tags
// Revision: 1.0 - initial release
// ============================================================================
module adder_sched_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_scheduler
// Purpose : Round-robin sharing of one 33-input fp32 adder between NUM_REQ
//           requesters.  A winner is granted for exactly VECTOR_LEN cycles and
//           its words are streamed contiguously to the adder; each frame's
//           owner ID is queued so returning sums come back labelled.
// Ports   : clk, rst_n              - clock, asynchronous active-low reset
//           i_req, i_data           - per-requester request and data word
//           o_grant                 - one-hot grant (held for a whole frame)
//           o_add_valid, o_add_data - beat stream into the adder
//           i_add_valid, i_add_data - adder result
//           o_res_valid, o_res_data, o_res_id - tagged result
//           o_busy                  - streaming or results still outstanding
//           o_err                   - sticky error (ADDER_SCHED_ERR_EN only)
// Config  : `define ADDER_SCHED_ERR_EN adds o_err, set on a result arriving
//           with no frame outstanding or on a tag overflow attempt.
// Revision: 1.0 - initial release
// ============================================================================
module adder_share_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int VECTOR_LEN = DEFAULT_VECTOR_LEN,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_add_valid,
  output logic [DATA_WIDTH-1:0]         o_add_data,
  input  logic                          i_add_valid,
  input  logic [DATA_WIDTH-1:0]         i_add_data,
  output logic                          o_res_valid,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  output logic [$clog2(NUM_REQ)-1:0]    o_res_id,
  output logic                          o_busy
`ifdef ADDER_SCHED_ERR_EN
  ,
  output logic                          o_err
`endif
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(VECTOR_LEN);
  localparam int FCNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VECTOR_LEN - 1);

  sched_state_t        state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]     cur_id, cur_id_nxt;
  logic [CNT_W-1:0]    beat, beat_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [ID_W-1:0]     winner;
  logic [MAX_REQ-1:0]  req_pad;
  logic                any_req;
  logic                can_start;
  logic                launch;
  logic                tag_push;
  logic                tag_pop;
  logic                tag_full;
  logic                tag_empty;
  logic [ID_W-1:0]     tag_head;
  logic [FCNT_W-1:0]   tag_count;
  logic [DATA_WIDTH-1:0] sel_data;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = i_req;
  end

  assign any_req = |i_req;
  assign winner  = ID_W'(rr_pick(req_pad, 4'(rr_ptr), NUM_REQ));
  assign tag_pop = i_add_valid && !tag_empty;
  // A full FIFO still accepts a new tag when the head leaves this same cycle.
  assign can_start = any_req && (!tag_full || tag_pop);

  // --------------------------------------------------------------------------
  // FSM: next state, grant and beat counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cur_id_nxt = cur_id;
    beat_nxt   = beat;
    grant_nxt  = o_grant;
    launch     = 1'b0;

    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (can_start) begin
          state_nxt = STREAM;
          launch    = 1'b1;
        end
      end
      STREAM: begin
        if (beat == LAST_BEAT) begin
          // Wrapping exactly here keeps back-to-back frames aligned to the
          // adder's VECTOR_LEN framing with no idle beat in between.
          beat_nxt = '0;
          if (can_start) begin
            launch = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        beat_nxt  = '0;
      end
    endcase

    if (launch) begin
      cur_id_nxt = winner;
      rr_ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        grant_nxt[k] = (winner == ID_W'(k));
      end
    end
  end

  assign tag_push = launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cur_id  <= '0;
      beat    <= '0;
      o_grant <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      cur_id  <= cur_id_nxt;
      beat    <= beat_nxt;
      o_grant <= grant_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Beat path: forward the granted requester's word one cycle later
  // --------------------------------------------------------------------------
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cur_id == ID_W'(k)) sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_add_valid <= 1'b0;
      o_add_data  <= '0;
    end else begin
      o_add_valid <= |o_grant;
      o_add_data  <= (|o_grant) ? sel_data : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Tag FIFO and result path
  // --------------------------------------------------------------------------
  adder_sched_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (winner),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_id    <= '0;
    end else begin
      // A result with nothing outstanding is dropped: no pulse, no pop.
      o_res_valid <= tag_pop;
      if (tag_pop) begin
        o_res_data <= i_add_data;
        o_res_id   <= tag_head;
      end
    end
  end

`ifdef ADDER_SCHED_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if ((i_add_valid && tag_empty) || (tag_push && tag_full && !tag_pop)) begin
      o_err <= 1'b1;
    end
  end
`endif

  assign o_busy = (state == STREAM) || (tag_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_scheduler.sv
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_adder_share_scheduler
// Purpose : Self-checking bench for adder_share_scheduler.  Requester models
//           present random small-integer fp32 frames, an adder model sums each
//           frame after a programmable latency, and each scenario task checks
//           grants and tagged results against a round-robin reference model.
// Config  : compile with +define+ADDER_SCHED_ERR_EN to also check o_err.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_share_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 32;
  localparam int VL        = 33;
  localparam int TAG_DEPTH = 2;
  localparam int ID_W      = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     i_req = '0;
  logic [NUM_REQ*DW-1:0]  i_data = '0;
  logic [NUM_REQ-1:0]     o_grant;
  logic                   o_add_valid;
  logic [DW-1:0]          o_add_data;
  logic                   i_add_valid = 1'b0;
  logic [DW-1:0]          i_add_data = '0;
  logic                   o_res_valid;
  logic [DW-1:0]          o_res_data;
  logic [ID_W-1:0]        o_res_id;
  logic                   o_busy;
`ifdef ADDER_SCHED_ERR_EN
  logic                   o_err;
`endif

  adder_share_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .VECTOR_LEN (VL),
    .TAG_DEPTH  (TAG_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_data      (i_data),
    .o_grant     (o_grant),
    .o_add_valid (o_add_valid),
    .o_add_data  (o_add_data),
    .i_add_valid (i_add_valid),
    .i_add_data  (i_add_data),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .o_res_id    (o_res_id),
    .o_busy      (o_busy)
`ifdef ADDER_SCHED_ERR_EN
    ,
    .o_err       (o_err)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- state
  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  int          remaining [NUM_REQ];
  int          gcnt      [NUM_REQ];
  logic [31:0] frame     [NUM_REQ][VL];
  bit          ones_mode = 1'b0;

  int          start_id_q  [$];
  int          start_cyc_q [$];
  logic [31:0] exp_sum_q   [$];
  int          res_id_q    [$];
  logic [31:0] res_data_q  [$];
  int          res_cyc_q   [$];
  int          grant_cycles = 0;
  bit          onehot_err   = 1'b0;

  int          acc = 0;
  int          acc_beats = 0;
  logic [31:0] add_out_q [$];
  int          add_due_q [$];
  int          add_lat = 4;
  bit          spurious_req = 1'b0;

  int          model_ptr = 0;
  int          exp_ids [$];

  // ---------------------------------------------------------------- fp helpers
  // Small non-negative integers only, so every sum is exact in fp32.
  function automatic logic [31:0] int2fp(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    int e;
    logic [31:0] man;
    if (f[30:0] == 31'h0) return 0;
    e   = int'(f[30:23]) - 127;
    man = {8'h0, 1'b1, f[22:0]};
    return int'(man >> (23 - e));
  endfunction

  // ---------------------------------------------------------------- RR model
  function automatic int rr_next(input int ptr, input bit [NUM_REQ-1:0] mask);
    int idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (ptr + i) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Every requester in mask keeps requesting until served once.
  function automatic void model_serve(input bit [NUM_REQ-1:0] mask);
    bit [NUM_REQ-1:0] m;
    int w;
    m = mask;
    exp_ids.delete();
    while (m != '0) begin
      w = rr_next(model_ptr, m);
      exp_ids.push_back(w);
      m[w] = 1'b0;
      model_ptr = (w + 1) % NUM_REQ;
    end
  endfunction

  // ---------------------------------------------------------------- models
  always @(negedge clk) begin
    int sum;
    cycle++;
    if (o_res_valid) begin
      res_id_q.push_back(int'(o_res_id));
      res_data_q.push_back(o_res_data);
      res_cyc_q.push_back(cycle);
    end
    if (o_grant != '0) begin
      grant_cycles++;
      if (!$onehot(o_grant)) onehot_err = 1'b1;
    end
    // adder: sum VL beats, deliver after add_lat cycles
    if (o_add_valid) begin
      acc += fp2int(o_add_data);
      acc_beats++;
      if (acc_beats == VL) begin
        add_out_q.push_back(int2fp(acc));
        add_due_q.push_back(cycle + add_lat);
        acc = 0;
        acc_beats = 0;
      end
    end
    i_add_valid = 1'b0;
    i_add_data  = $urandom;
    if (spurious_req) begin
      i_add_valid  = 1'b1;
      spurious_req = 1'b0;
    end else if (add_due_q.size() > 0 && add_due_q[0] <= cycle) begin
      i_add_valid = 1'b1;
      i_add_data  = add_out_q.pop_front();
      void'(add_due_q.pop_front());
    end
    // requesters: present element n on the n-th grant cycle
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant[k]) begin
        if (gcnt[k] == 0) begin
          sum = 0;
          for (int n = 0; n < VL; n++) begin
            if (ones_mode) begin
              frame[k][n] = 32'h3F80_0000;
              sum += 1;
            end else begin
              int v;
              v = int'($urandom_range(15, 0));
              frame[k][n] = int2fp(v);
              sum += v;
            end
          end
          exp_sum_q.push_back(int2fp(sum));
          start_id_q.push_back(k);
          start_cyc_q.push_back(cycle);
          if (remaining[k] > 0) remaining[k]--;
          if (remaining[k] == 0) i_req[k] = 1'b0;
        end
        i_data[k*DW +: DW] = frame[k][gcnt[k]];
        gcnt[k] = (gcnt[k] == VL - 1) ? 0 : gcnt[k] + 1;
      end else begin
        i_data[k*DW +: DW] = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------- utilities
  task automatic clear_logs();
    start_id_q.delete(); start_cyc_q.delete(); exp_sum_q.delete();
    res_id_q.delete(); res_data_q.delete(); res_cyc_q.delete();
    grant_cycles = 0;
    onehot_err   = 1'b0;
  endtask

  task automatic clear_models();
    for (int k = 0; k < NUM_REQ; k++) begin
      remaining[k] = 0;
      gcnt[k] = 0;
    end
    i_req = '0;
    acc = 0;
    acc_beats = 0;
    add_out_q.delete();
    add_due_q.delete();
    clear_logs();
  endtask

  task automatic request(input bit [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[k]) begin
        remaining[k] = 1;
        i_req[k] = 1'b1;
      end
    end
  endtask

  task automatic run_quiet(output bit ok);
    int n;
    int stable;
    n = 0; stable = 0; ok = 1'b0;
    while (n < 3000) begin
      @(negedge clk); #1;
      n++;
      if (i_req == '0 && !o_busy && add_due_q.size() == 0 && acc_beats == 0 && !o_add_valid)
        stable++;
      else
        stable = 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    clear_models();
    model_ptr = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clear_models();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (o_grant !== '0)     $display("FAIL reset_grant: got %h want 0", o_grant);          else passes++;
    checks++; if (o_add_valid !== 0)  $display("FAIL reset_add_valid: got %b want 0", o_add_valid); else passes++;
    checks++; if (o_add_data !== '0)  $display("FAIL reset_add_data: got %h want 0", o_add_data);   else passes++;
    checks++; if (o_res_valid !== 0)  $display("FAIL reset_res_valid: got %b want 0", o_res_valid); else passes++;
    checks++; if (o_res_data !== '0)  $display("FAIL reset_res_data: got %h want 0", o_res_data);   else passes++;
    checks++; if (o_res_id !== '0)    $display("FAIL reset_res_id: got %0d want 0", o_res_id);      else passes++;
    checks++; if (o_busy !== 0)       $display("FAIL reset_busy: got %b want 0", o_busy);           else passes++;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_ones();
    bit ok;
    int req_cyc;
    clear_logs();
    ones_mode = 1'b1;
    @(negedge clk); #1;
    req_cyc = cycle;
    model_serve(4'b0001);
    request(4'b0001);
    run_quiet(ok);
    ones_mode = 1'b0;
    checks++; if (!ok) $display("FAIL single_timeout: got busy want idle"); else passes++;
    checks++; if (start_id_q.size() != 1 || start_id_q[0] != exp_ids[0])
      $display("FAIL single_grant_id: got %p want %p", start_id_q, exp_ids); else passes++;
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != req_cyc + 1)
      $display("FAIL single_grant_latency: got %p want %0d", start_cyc_q, req_cyc + 1); else passes++;
    checks++; if (grant_cycles != VL || onehot_err)
      $display("FAIL single_grant_width: got %0d (onehot_err=%0b) want %0d", grant_cycles, onehot_err, VL); else passes++;
    checks++; if (res_data_q.size() != 1 || res_data_q[0] !== 32'h4204_0000)
      $display("FAIL single_sum: got %p want 42040000", res_data_q); else passes++;
    checks++; if (res_id_q.size() != 1 || res_id_q[0] != 0)
      $display("FAIL single_id: got %p want 0", res_id_q); else passes++;
  endtask

  task automatic test_all_together();
    bit ok;
    int got;
    do_reset();
    @(negedge clk); #1;
    model_serve(4'b1111);
    request(4'b1111);
    run_quiet(ok);
    checks++; if (!ok) $display("FAIL all_timeout: got busy want idle"); else passes++;
    for (int i = 0; i < NUM_REQ; i++) begin
      got = (i < start_id_q.size()) ? start_id_q[i] : -1;
      checks++; if (got != exp_ids[i]) $display("FAIL all_grant_order[%0d]: got %0d want %0d", i, got, exp_ids[i]); else passes++;
      got = (i < res_id_q.size()) ? res_id_q[i] : -1;
      checks++; if (got != exp_ids[i]) $display("FAIL all_res_id[%0d]: got %0d want %0d", i, got, exp_ids[i]); else passes++;
      checks++; if (i >= res_data_q.size() || i >= exp_sum_q.size() || res_data_q[i] !== exp_sum_q[i])
        $display("FAIL all_res_data[%0d]: got %p want %p", i, res_data_q, exp_sum_q); else passes++;
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      got = (i < start_cyc_q.size()) ? start_cyc_q[i] - start_cyc_q[i-1] : -1;
      checks++; if (got != VL) $display("FAIL all_back_to_back[%0d]: got gap %0d want %0d", i, got, VL); else passes++;
    end
    checks++; if (grant_cycles != NUM_REQ * VL) $display("FAIL all_grant_cycles: got %0d want %0d", grant_cycles, NUM_REQ * VL); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int got;
    int want;
    clear_logs();
    add_lat = 200;
    @(negedge clk); #1;
    model_serve(4'b0111);
    request(4'b0111);
    run_quiet(ok);
    add_lat = 4;
    checks++; if (!ok) $display("FAIL bp_timeout: got busy want idle"); else passes++;
    checks++; if (start_cyc_q.size() != 3 || res_cyc_q.size() != 3)
      $display("FAIL bp_counts: got %0d grants %0d results want 3 and 3", start_cyc_q.size(), res_cyc_q.size()); else passes++;
    got  = (start_cyc_q.size() > 1) ? start_cyc_q[1] - start_cyc_q[0] : -1;
    checks++; if (got != VL) $display("FAIL bp_second_gap: got %0d want %0d", got, VL); else passes++;
    // third frame waits for the first pop and starts on the very next cycle
    got  = (start_cyc_q.size() > 2) ? start_cyc_q[2] : -1;
    want = (res_cyc_q.size() > 0) ? res_cyc_q[0] : -2;
    checks++; if (got != want) $display("FAIL bp_third_start: got cycle %0d want %0d", got, want); else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (i < res_id_q.size()) ? res_id_q[i] : -1;
      checks++; if (got != exp_ids[i]) $display("FAIL bp_res_id[%0d]: got %0d want %0d", i, got, exp_ids[i]); else passes++;
      checks++; if (i >= res_data_q.size() || i >= exp_sum_q.size() || res_data_q[i] !== exp_sum_q[i])
        $display("FAIL bp_res_data[%0d]: got %p want %p", i, res_data_q, exp_sum_q); else passes++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int got;
    clear_logs();
    @(negedge clk); #1;
    model_serve(4'b0100);
    request(4'b0100);
    run_quiet(ok);
    checks++; if (!ok || start_id_q.size() != 1 || start_id_q[0] != 2)
      $display("FAIL rr_first: got %p want 2", start_id_q); else passes++;
    clear_logs();
    @(negedge clk); #1;
    model_serve(4'b1010);
    request(4'b1010);
    run_quiet(ok);
    checks++; if (!ok) $display("FAIL rr_timeout: got busy want idle"); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = (i < start_id_q.size()) ? start_id_q[i] : -1;
      checks++; if (got != exp_ids[i]) $display("FAIL rr_order[%0d]: got %0d want %0d", i, got, exp_ids[i]); else passes++;
      got = (i < res_id_q.size()) ? res_id_q[i] : -1;
      checks++; if (got != exp_ids[i]) $display("FAIL rr_res_id[%0d]: got %0d want %0d", i, got, exp_ids[i]); else passes++;
    end
    checks++; if (res_data_q.size() != 2 || exp_sum_q.size() != 2 || res_data_q[1] !== exp_sum_q[1])
      $display("FAIL rr_res_data: got %p want %p", res_data_q, exp_sum_q); else passes++;
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    int n;
    int req_cyc;
    clear_logs();
    @(negedge clk); #1;
    request(4'b0001);
    n = 0;
    while (gcnt[0] != 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (gcnt[0] != 11) $display("FAIL mid_reach_beat10: got %0d want 11", gcnt[0]); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_grant !== '0)     $display("FAIL mid_grant: got %h want 0", o_grant);          else passes++;
    checks++; if (o_add_valid !== 0)  $display("FAIL mid_add_valid: got %b want 0", o_add_valid); else passes++;
    checks++; if (o_add_data !== '0)  $display("FAIL mid_add_data: got %h want 0", o_add_data);   else passes++;
    checks++; if (o_res_valid !== 0)  $display("FAIL mid_res_valid: got %b want 0", o_res_valid); else passes++;
    checks++; if (o_res_data !== '0)  $display("FAIL mid_res_data: got %h want 0", o_res_data);   else passes++;
    checks++; if (o_res_id !== '0)    $display("FAIL mid_res_id: got %0d want 0", o_res_id);      else passes++;
    checks++; if (o_busy !== 0)       $display("FAIL mid_busy: got %b want 0", o_busy);           else passes++;
    clear_models();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    req_cyc = cycle;
    model_serve(4'b0010);
    request(4'b0010);
    run_quiet(ok);
    checks++; if (!ok) $display("FAIL mid_after_timeout: got busy want idle"); else passes++;
    checks++; if (start_id_q.size() != 1 || start_id_q[0] != exp_ids[0] || start_cyc_q[0] != req_cyc + 1)
      $display("FAIL mid_after_grant: got %p at %p want %0d at %0d", start_id_q, start_cyc_q, exp_ids[0], req_cyc + 1); else passes++;
    checks++; if (grant_cycles != VL) $display("FAIL mid_after_width: got %0d want %0d", grant_cycles, VL); else passes++;
    checks++; if (res_data_q.size() != 1 || exp_sum_q.size() != 1 || res_data_q[0] !== exp_sum_q[0] || res_id_q[0] != exp_ids[0])
      $display("FAIL mid_after_result: got %p id %p want %p id %0d", res_data_q, res_id_q, exp_sum_q, exp_ids[0]); else passes++;
  endtask

  task automatic test_spurious();
    bit ok;
    run_quiet(ok);
    checks++; if (!ok) $display("FAIL spur_quiet: got busy want idle"); else passes++;
`ifdef ADDER_SCHED_ERR_EN
    checks++; if (o_err !== 1'b0) $display("FAIL spur_err_before: got %b want 0", o_err); else passes++;
`endif
    clear_logs();
    spurious_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (res_data_q.size() != 0) $display("FAIL spur_res_valid: got %0d results want 0", res_data_q.size()); else passes++;
    checks++; if (o_busy !== 1'b0) $display("FAIL spur_busy: got %b want 0", o_busy); else passes++;
`ifdef ADDER_SCHED_ERR_EN
    checks++; if (o_err !== 1'b1) $display("FAIL spur_err: got %b want 1", o_err); else passes++;
`endif
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single_ones();
    test_all_together();
    test_backpressure();
    test_round_robin();
    test_reset_mid_stream();
    test_spurious();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion want finish before 900us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_share_scheduler.md
# adder_share_scheduler

Round-robin scheduler that shares one `adder_33_input_pipeline_floating_point32` instance between `NUM_REQ` neuron-node requesters. Each requester needs one 33-element fp32 frame (32 products plus bias) summed. The scheduler grants one requester at a time and streams its frame contiguously into the adder. It tags each frame in an in-order tag FIFO and returns each adder result labelled with the originating requester ID. It sits between the per-node MAC stages and the shared adder in each DQN layer.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters (2..16).
- `DATA_WIDTH`, default 32: fp32 word width.
- `VECTOR_LEN`, default 33: words per frame.
- `TAG_DEPTH`, default 4: maximum frames in flight inside the adder (power of 2).

**Ports** (`ID_W` = $clog2(NUM_REQ))
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `i_req`, input, NUM_REQ: per-requester request level.
- `i_data`, input, NUM_REQ*DATA_WIDTH: requester k drives bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_grant`, output, NUM_REQ: one-hot grant; requester k presents element n on the n-th grant cycle.
- `o_add_valid`, output, 1: frame beat to the adder (drives its i_valid).
- `o_add_data`, output, DATA_WIDTH: beat data to the adder.
- `i_add_valid`, input, 1: adder result valid.
- `i_add_data`, input, DATA_WIDTH: adder result.
- `o_res_valid`, output, 1: tagged result valid.
- `o_res_data`, output, DATA_WIDTH: result value.
- `o_res_id`, output, ID_W: requester that owns the result.
- `o_busy`, output, 1: high while streaming or while the tag FIFO is non-empty.

## Operation

- FSM has two states, IDLE and STREAM. Reset state is IDLE, with the RR pointer at 0 (requester 0 has top priority) and the beat counter at 0.
- **IDLE → STREAM**: when any `i_req` is high and the tag FIFO is not full.
  - Winner = first requester at or after the RR pointer, cyclic.
  - Register `o_grant` one-hot for the winner, push the winner ID into the tag FIFO, set the RR pointer to winner+1 mod NUM_REQ.
- **STREAM**: the grant is held for exactly VECTOR_LEN cycles; the counter runs 0..VECTOR_LEN-1.
  - `i_req` changes are ignored; a granted requester is committed for the full frame.
- **Last beat** (counter = VECTOR_LEN-1):
  - If another eligible request exists and the FIFO is not full (counting a same-cycle pop), the next grant starts on the following cycle with no bubble, and the state stays STREAM.
  - Otherwise the state returns to IDLE and `o_grant` goes to 0.
  - Back-to-back frames keep the adder's frame alignment because the counter wraps exactly at VECTOR_LEN.
- **Beat path**: `o_add_data` is registered as the `i_data` slice of the granted requester; `o_add_valid` is registered as |`o_grant`.
- **Result path**: on `i_add_valid`, pop the FIFO head. Register `o_res_valid`=1, `o_res_data`=`i_add_data`, `o_res_id`=head.
- **FIFO full check**: `count + push - pop <= TAG_DEPTH`. A simultaneous push and pop while full is allowed.
- **Spurious result** (`i_add_valid` with the FIFO empty): no pop, and `o_res_valid` stays 0.
- **Reset mid-operation**: all state, the counter and the FIFO clear immediately. The shared `rst_n` also flushes the adder.

## Timing

- Reset values: `o_grant`=0, `o_add_valid`=0, `o_add_data`=0, `o_res_valid`=0, `o_res_data`=0, `o_res_id`=0, `o_busy`=0.
- Request to first grant: 1 cycle (`i_req` sampled at edge t, `o_grant` high after edge t).
- Grant to adder beat: 1 cycle (beat n of the frame appears on `o_add_*` one cycle after grant cycle n).
- Adder result to `o_res_*`: 1 cycle.
- `o_res_valid` is a one-cycle pulse per frame.
- Grant width is exactly VECTOR_LEN cycles.
- Peak throughput is one frame per VECTOR_LEN cycles.

## Configuration

- Macro: `ADDER_SCHED_ERR_EN`.
- **Defined**: adds output `o_err` (1 bit, reset 0). It is sticky until reset and sets on a spurious result or on a tag FIFO overflow attempt (a defensive check that is unreachable in correct operation).
- **Undefined**: the port is absent and spurious results are dropped silently.

## Structure

- Package `adder_sched_pkg` holds:
  - the FP32 width constant;
  - the default VECTOR_LEN (33);
  - the FSM state enum {IDLE, STREAM};
  - the helper function for cyclic priority search.
- Sub-module `adder_sched_tag_fifo`: synchronous FIFO of ID_W-bit tags.
  - Depth TAG_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Uses the same `clk`/`rst_n`.

## Test plan

1. **Single frame, all ones.** Requester 0 requests with all 33 words = 0x3F800000. Required: grant held exactly 33 cycles; `o_res_data`=0x42040000 (33.0); `o_res_id`=0.
2. **All requesters together.** Requesters 0..3 request simultaneously. Required: grant order 0,1,2,3 back-to-back with no idle cycle; 4 results with IDs 0,1,2,3 in order.
3. **Tag FIFO backpressure.** TAG_DEPTH=2, slow adder model (latency 200), continuous requests. Required: a third grant is withheld until the first result pops, then starts the next cycle.
4. **Round-robin pointer.** Requester 2 served, then requesters 1 and 3 request together. Required: 3 is granted before 1.
5. **Reset mid-stream.** Assert `rst_n`=0 at beat 10. Required: all outputs return to reset values immediately; after release, a fresh frame starts at counter 0 and yields the correct sum.
6. **Spurious result.** `i_add_valid` pulses while the FIFO is empty. Required: no `o_res_valid`; `o_err`=1 with `ADDER_SCHED_ERR_EN` defined.
